// File: rtl/mfp_uart_pkg.sv
// mfp_uart_pkg
// Shared definitions for the UART receive path: the receive FSM state
// encoding and the default clock and line-rate constants.
package mfp_uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD     = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/mfp_uart_rx_fifo.sv
// mfp_uart_rx_fifo
// Generic synchronous circular-buffer FIFO with depth 2**FIFO_AW.
// A push while full is ignored. A pop while empty is ignored.
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   push, push_data write request and data
//   pop             read request; head_data is the current head entry
//   full, empty     occupancy flags
//   level           occupancy, 0..2**FIFO_AW
module mfp_uart_rx_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  assign head_data = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mfp_uart_rx_buffered.sv
// mfp_uart_rx_buffered
// UART 8N1 receiver with a byte FIFO and rate-limited drain towards the
// SREC parser. rx is synchronised, bytes are recovered by mid-bit sampling,
// queued, and handed out as single-cycle byte_ready strobes spaced by at
// least DRAIN_GAP idle cycles.
// Optional feature macro: MFP_UART_RX_ERRCNT_EN adds err_count, a saturating
// count of framing errors plus overrun drops.
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   rx              raw UART line, idle high
//   byte_data       byte presented with byte_ready, held until the next pop
//   byte_ready      one-cycle strobe
//   fifo_level      FIFO occupancy
//   overrun         sticky, a byte arrived with the FIFO full
//   framing_error   one-cycle pulse on a low stop bit
//   err_count       (MFP_UART_RX_ERRCNT_EN only) saturating error count
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; push on high, framing error on low
module mfp_uart_rx_buffered
  import mfp_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD      = DEFAULT_BAUD,
  parameter int          FIFO_AW   = 4,
  parameter int unsigned DRAIN_GAP = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rx,
  output logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overrun,
  output logic               framing_error
`ifdef MFP_UART_RX_ERRCNT_EN
  ,
  output logic [7:0]         err_count
`endif
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       GAP_LOAD  = 4'(DRAIN_GAP);

  logic rx_meta;
  logic rs;
  logic rs_prev;

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             push;
  logic             ferr_det;

  logic [7:0] head_data;
  logic       full;
  logic       empty;
  logic       pop;
  logic [3:0] gap_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
      rs_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
      rs_prev <= rs;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr_det  = 1'b0;
    case (state)
      IDLE: begin
        if (rs_prev && !rs) begin
          cnt_n   = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rs) begin
            cnt_n     = BIT_LOAD;
            bit_idx_n = '0;
            state_n   = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          // Shift in from the top so the first (LSB) bit ends at bit 0.
          shreg_n = {rs, shreg[7:1]};
          cnt_n   = BIT_LOAD;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          push     = rs;
          ferr_det = !rs;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  mfp_uart_rx_fifo #(
    .WIDTH   (8),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign pop = !empty && (gap_cnt == 4'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt       <= 4'd0;
      byte_data     <= 8'h00;
      byte_ready    <= 1'b0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      byte_ready    <= pop;
      framing_error <= ferr_det;
      if (pop) begin
        byte_data <= head_data;
        gap_cnt   <= GAP_LOAD;
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
      if (push && full) overrun <= 1'b1;
    end
  end

`ifdef MFP_UART_RX_ERRCNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= 8'h00;
    end else if ((ferr_det || (push && full)) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
